// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, WORD_SIZE data bits LSB first, one stop bit,
// each bit held for PULSE_WIDTH clocks. tx and tx_ready are registered.
module uart_transmitter #(
  parameter int WORD_SIZE   = 8,
  parameter int PULSE_WIDTH = 868,
  parameter int PACKET_SIZE = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 send_valid,
  input  logic [WORD_SIZE-1:0] data_bits,
  output logic                 tx_ready,
  output logic                 tx
);

  localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam int BCW = $clog2(PACKET_SIZE);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(WORD_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_reg;
  logic [PCW-1:0]       pulse_cnt_reg;
  logic [BCW-1:0]       bit_cnt_reg;
  logic [WORD_SIZE-1:0] shift_reg;
  logic                 tx_reg;
  logic                 tx_ready_reg;
  logic                 pulse_done;

  assign pulse_done = (pulse_cnt_reg == PULSE_LAST);
  assign tx         = tx_reg;
  assign tx_ready   = tx_ready_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      pulse_cnt_reg <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      tx_reg        <= 1'b1;
      tx_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          pulse_cnt_reg <= '0;
          bit_cnt_reg   <= '0;
          if (send_valid) begin
            shift_reg    <= data_bits;
            tx_reg       <= 1'b0;
            tx_ready_reg <= 1'b0;
            state_reg    <= START;
          end
        end
        START: begin
          if (pulse_done) begin
            pulse_cnt_reg <= '0;
            tx_reg        <= shift_reg[0];
            state_reg     <= DATA;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (pulse_done) begin
            pulse_cnt_reg <= '0;
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_reg <= '0;
              tx_reg      <= 1'b1;
              state_reg   <= STOP;
            end else begin
              // Present the next bit on the same edge the register shifts.
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (pulse_done) begin
            pulse_cnt_reg <= '0;
            tx_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          tx_reg       <= 1'b1;
          tx_ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with PULSE_WIDTH=4: per-clock frame
// checks plus an independent serial decoder for the random-word run.
module tb_uart_transmitter;

  localparam int PW = 4;
  localparam int FRAME_CLKS = 10 * PW;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       send_valid = 1'b0;
  logic [7:0] data_bits = 8'h00;
  logic       tx_ready;
  logic       tx;

  int n_cmp = 0;
  int n_err = 0;

  logic       mon_en = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_transmitter #(
    .WORD_SIZE  (8),
    .PULSE_WIDTH(PW),
    .PACKET_SIZE(10)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .send_valid(send_valid),
    .data_bits (data_bits),
    .tx_ready  (tx_ready),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int i);
    int b;
    b = i / PW;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Waits for tx_ready, accepts d on the next edge, then checks every clock
  // of the frame. Optionally pokes send_valid mid-frame. Returns the number
  // of clocks spent waiting for tx_ready.
  task automatic run_frame(input logic [7:0] d, input bit poke, input string tag,
                           output int waited);
    int n;
    int bad;
    n = 0;
    bad = n_err;
    data_bits  = d;
    send_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_ready_wait"}, 32'(tx_ready), 1);
    waited = n;
    @(posedge clk); #1;
    send_valid = 1'b0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      check($sformatf("%s_tx%0d", tag, i), 32'(tx), 32'(exp_bit(d, i)));
      check($sformatf("%s_busy%0d", tag, i), 32'(tx_ready), 0);
      data_bits  = 8'($urandom);
      send_valid = poke && (i % 5 == 2);
      @(posedge clk); #1;
    end
    send_valid = 1'b0;
    check({tag, "_ready_end"}, 32'(tx_ready), 1);
    check({tag, "_tx_end"}, 32'(tx), 1);
    $display("frame %s data=0x%02h wait=%0d %s", tag, d, waited,
             (n_err == bad) ? "ok" : "bad");
  endtask

  // Independent decoder: finds the start bit and samples mid-bit.
  initial begin
    logic [7:0] w;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (PW / 2) @(negedge clk);
        check("mon_start", 32'(tx), 0);
        for (int b = 0; b < 8; b++) begin
          repeat (PW) @(negedge clk);
          w[b] = tx;
        end
        repeat (PW) @(negedge clk);
        check("mon_stop", 32'(tx), 1);
        got_q.push_back(w);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    logic [7:0] d;

    // 1. Reset
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_tx", 32'(tx), 1);
      check("rst_ready", 32'(tx_ready), 1);
    end
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("post_rst_tx", 32'(tx), 1);
      check("post_rst_ready", 32'(tx_ready), 1);
    end
    $display("reset done");

    // 2. Single frame
    run_frame(8'hA5, 1'b0, "a5", waited);

    // 3. send_valid pulses mid-frame are ignored
    run_frame(8'h3C, 1'b1, "poke", waited);
    for (int i = 0; i < 10; i++) begin
      check("no_second_ready", 32'(tx_ready), 1);
      check("no_second_tx", 32'(tx), 1);
      @(posedge clk); #1;
    end

    // 4. Back-to-back frames
    run_frame(8'h00, 1'b0, "b2b_00", waited);
    run_frame(8'hFF, 1'b0, "b2b_ff", waited);
    check("b2b_gap", waited, 0);

    // 5. Reset during data bit 3
    data_bits  = 8'hA5;
    send_valid = 1'b1;
    @(posedge clk); #1;
    send_valid = 1'b0;
    repeat (PW * 4 + 1) @(posedge clk);
    #2;
    check("pre_abort_tx", 32'(tx), 0);
    rstn = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 1);
    check("abort_ready", 32'(tx_ready), 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    $display("reset abort done");
    run_frame(8'h96, 1'b0, "after_abort", waited);

    // 6. Random words with random gaps, decoded by the monitor
    mon_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #1;
      d = 8'($urandom);
      exp_q.push_back(d);
      run_frame(d, 1'b0, $sformatf("rnd%0d", k), waited);
    end
    repeat (10) @(posedge clk);
    mon_en = 1'b0;
    check("mon_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("mon_word%0d", k), 32'(got_q[k]), 32'(exp_q[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
